opb_arbiter: RTL and testbench
==============================

# opb_arbiter

Registered round-robin arbiter and timeout monitor for the shared OPB segment behind the GPMC bridge. It grants the bus to one of up to NUM_MASTERS OPB masters (the gpmc_opb_bridge is master 0), honours bus locking, and raises OPB_timeout when a selected transfer receives no slave acknowledge. All masters and slaves run on OPB_Clk.

## Interface
- NUM_MASTERS, 4, number of requesting masters, 2..8
- TIMEOUT_CYCLES, 16, cycles of select without ack before timeout, 4..255
- IDX_W, $clog2(NUM_MASTERS), width of owner index (derived, not overridden)

Ports:
- OPB_Clk  in  1  bus clock, all logic rising-edge
- OPB_Rst_n  in  1  reset, asynchronous assert, active-low
- M_request  in  NUM_MASTERS  per-master bus request
- M_busLock  in  NUM_MASTERS  per-master lock
- M_select  in  NUM_MASTERS  per-master select
- OPB_xferAck  in  1  OR of slave acks
- OPB_retry  in  1  OR of slave retries
- OPB_errAck  in  1  OR of slave errors
- OPB_MGrant  out  NUM_MASTERS  one-hot grant, registered
- OPB_select  out  1  OR of M_select, combinational
- OPB_busLock  out  1  M_busLock of current owner, combinational
- OPB_timeout  out  1  one-cycle timeout pulse, registered
- owner  out  IDX_W  index of current or last owner, registered

## Operation
- States: IDLE, GRANT, BUSY, TOUT.
- Reset values: state IDLE, OPB_MGrant 0, OPB_timeout 0, owner 0, priority pointer 0 (master 0 highest), counter 0.
- IDLE: if any M_request, pick first requester at or after pointer (wrapping past NUM_MASTERS-1 to 0); set owner, assert its grant bit, go GRANT, clear counter. No request: stay, grants 0.
- GRANT: grant held. M_select[owner]=1 -> drop grant, go BUSY, clear counter. M_request[owner]=0 -> drop grant, pointer = owner+1 (wrapped), go IDLE. Counter reaches TIMEOUT_CYCLES-1 -> drop grant, advance pointer, go IDLE; no OPB_timeout pulse.
- BUSY: counter increments each cycle; cleared on OPB_xferAck, OPB_retry or OPB_errAck. Counter reaches TIMEOUT_CYCLES-1 with no ack this cycle -> OPB_timeout=1 next cycle, go TOUT.
- BUSY, M_select[owner] falls: if M_busLock[owner] and M_request[owner] -> re-grant same owner, go GRANT, pointer unchanged (no other master may win). Otherwise pointer = owner+1, go IDLE.
- TOUT: OPB_timeout returns 0 after one cycle; wait for M_select[owner]=0, then advance pointer, go IDLE. Timeout is only reported, never re-pulsed while in TOUT.
- Selects from non-owners are not checked; they still OR into OPB_select.
- Ack, retry and errAck are treated identically for timeout purposes; the arbiter never interprets data.

## Timing
- Request to grant: request high at edge N in IDLE -> OPB_MGrant bit high after edge N+1 (1-cycle latency).
- Grant drops the cycle after select is sampled high; grant and select overlap exactly one cycle.
- Bus handover: select low at edge N -> new grant (any master) high after edge N+1; locked re-grant same latency.
- Timeout: with select held and no ack, OPB_timeout high exactly TIMEOUT_CYCLES cycles after entry to BUSY (or after last ack), width one cycle.
- Ack on the same edge that counter hits TIMEOUT_CYCLES-1 wins: no timeout, counter cleared.
- OPB_Rst_n low at any time, including mid-BUSY: all registered outputs to reset values immediately (asynchronous); first grant possible one edge after release.
- At most one OPB_MGrant bit high in any cycle.

## Test plan
- Single requester: M_request=4'b0100 -> OPB_MGrant=4'b0100 one cycle later, owner=2; assert M_select[2] -> grant 0 next cycle; ack, drop select -> IDLE, pointer 3.
- Round-robin: M_request=4'b1011 held, each master does one select/ack -> grant order 0,1,3,0; never 2.
- Bus lock: master 1 locked with request held, master 0 requesting -> after select falls OPB_MGrant=4'b0010 again; master 0 granted only after lock drops.
- Timeout: TIMEOUT_CYCLES=16, master 0 selected, no ack -> OPB_timeout single pulse 16 cycles after select; grant to next requester only after select falls.
- Retry/ack resets: OPB_retry at cycle 10 of select -> no timeout until 16 cycles after retry; ack at exact limit cycle -> no pulse.
- Reset mid-transfer: OPB_Rst_n low while BUSY with grant/timeout pending -> OPB_MGrant=0, OPB_timeout=0, owner=0 immediately; after release master 0 wins over master 3.

Source files
------------

// File: rtl/opb_arbiter.sv
// opb_arbiter: registered round-robin arbiter for the shared OPB segment.
// Also watches selected transfers and pulses OPB_timeout on missing acks.
module opb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
    input  logic                   OPB_Clk,
    input  logic                   OPB_Rst_n,
    input  logic [NUM_MASTERS-1:0] M_request,
    input  logic [NUM_MASTERS-1:0] M_busLock,
    input  logic [NUM_MASTERS-1:0] M_select,
    input  logic                   OPB_xferAck,
    input  logic                   OPB_retry,
    input  logic                   OPB_errAck,
    output logic [NUM_MASTERS-1:0] OPB_MGrant,
    output logic                   OPB_select,
    output logic                   OPB_busLock,
    output logic                   OPB_timeout,
    output logic [IDX_W-1:0]       owner
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] TOUT  = 2'd3;

    localparam logic [7:0]       LIMIT = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_MASTERS - 1);

    logic [1:0]             state;
    logic [IDX_W-1:0]       ptr;
    logic [7:0]             cnt;

    logic [IDX_W-1:0]       cand;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [IDX_W-1:0]       next_idx;

    logic own_req;
    logic own_sel;
    logic own_lock;
    logic any_ack;
    logic cnt_hit;

    assign OPB_select  = |M_select;
    assign own_req     = M_request[owner];
    assign own_sel     = M_select[owner];
    assign own_lock    = M_busLock[owner];
    assign OPB_busLock = own_lock;

    // Retry and error terminate the wait exactly like a normal ack.
    assign any_ack = OPB_xferAck | OPB_retry | OPB_errAck;
    assign cnt_hit = (cnt == LIMIT);

    assign next_idx = (owner == LAST) ? '0 : owner + IDX_W'(1);
    assign pick_oh  = NUM_MASTERS'(1) << pick_idx;
    assign owner_oh = NUM_MASTERS'(1) << owner;

    // First requester at or after the pointer, wrapping at the last master.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = ptr;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!pick_valid && M_request[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
            cand = (cand == LAST) ? '0 : cand + IDX_W'(1);
        end
    end

    // Arbitration FSM, grant register, watchdog counter and timeout pulse.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state       <= IDLE;
            OPB_MGrant  <= '0;
            OPB_timeout <= 1'b0;
            owner       <= '0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            OPB_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick_idx;
                        OPB_MGrant <= pick_oh;
                        state      <= GRANT;
                        cnt        <= '0;
                    end else begin
                        OPB_MGrant <= '0;
                    end
                end
                GRANT: begin
                    if (own_sel) begin
                        OPB_MGrant <= '0;
                        state      <= BUSY;
                        cnt        <= '0;
                    end else if (!own_req || cnt_hit) begin
                        // Withdrawn or never-used grant: pass the bus on.
                        OPB_MGrant <= '0;
                        ptr        <= next_idx;
                        state      <= IDLE;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BUSY: begin
                    if (!own_sel) begin
                        cnt <= '0;
                        if (own_lock && own_req) begin
                            // Locked owner keeps the bus; pointer frozen.
                            OPB_MGrant <= owner_oh;
                            state      <= GRANT;
                        end else begin
                            ptr   <= next_idx;
                            state <= IDLE;
                        end
                    end else if (any_ack) begin
                        cnt <= '0;
                    end else if (cnt_hit) begin
                        OPB_timeout <= 1'b1;
                        state       <= TOUT;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                TOUT: begin
                    if (!own_sel) begin
                        ptr   <= next_idx;
                        state <= IDLE;
                    end
                end
                default: begin
                    OPB_MGrant <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opb_arbiter.sv
// tb_opb_arbiter: directed vectors plus timeout and reset sequences.
// Expected values are hand-derived from the arbiter behaviour.
module tb_opb_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] sel;
    logic       ack;
    logic       retry;
    logic       err;
    logic [3:0] grant;
    logic       osel;
    logic       olock;
    logic       tout;
    logic [1:0] own;

    int checks;
    int failures;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] sel;
        logic [2:0] acks;
        logic [3:0] g;
        logic       to;
        logic [1:0] own;
        logic       osel;
        logic       olock;
    } vec_t;

    vec_t tbl[$];

    opb_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .OPB_Clk(clk),
        .OPB_Rst_n(rst_n),
        .M_request(req),
        .M_busLock(lock),
        .M_select(sel),
        .OPB_xferAck(ack),
        .OPB_retry(retry),
        .OPB_errAck(err),
        .OPB_MGrant(grant),
        .OPB_select(osel),
        .OPB_busLock(olock),
        .OPB_timeout(tout),
        .owner(own)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
    endtask

    task automatic v(input logic [3:0] r, input logic [3:0] l,
                     input logic [3:0] s, input logic [2:0] a,
                     input logic [3:0] g, input logic [1:0] o,
                     input logic os, input logic ol);
        vec_t e;
        e.req   = r;
        e.lock  = l;
        e.sel   = s;
        e.acks  = a;
        e.g     = g;
        e.to    = 1'b0;
        e.own   = o;
        e.osel  = os;
        e.olock = ol;
        tbl.push_back(e);
    endtask

    initial begin
        int first;
        int pulses;
        int gseen;
        int drop_c;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = '0;
        lock     = '0;
        sel      = '0;
        ack      = 1'b0;
        retry    = 1'b0;
        err      = 1'b0;

        // single requester
        v(4'b0100, 4'b0000, 4'b0000, 3'b000, 4'b0100, 2'd2, 0, 0);
        v(4'b0100, 4'b0000, 4'b0100, 3'b000, 4'b0000, 2'd2, 1, 0);
        v(4'b0100, 4'b0000, 4'b0100, 3'b001, 4'b0000, 2'd2, 1, 0);
        v(4'b0000, 4'b0000, 4'b1000, 3'b000, 4'b0000, 2'd2, 1, 0);
        // round robin 3,0,1,3 with 1011 held
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b1000, 2'd3, 0, 0);
        v(4'b1011, 4'b0000, 4'b1000, 3'b000, 4'b0000, 2'd3, 1, 0);
        v(4'b1011, 4'b0000, 4'b1000, 3'b001, 4'b0000, 2'd3, 1, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd3, 0, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b0001, 2'd0, 0, 0);
        v(4'b1011, 4'b0000, 4'b0001, 3'b000, 4'b0000, 2'd0, 1, 0);
        v(4'b1011, 4'b0000, 4'b0001, 3'b010, 4'b0000, 2'd0, 1, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd0, 0, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b0010, 2'd1, 0, 0);
        v(4'b1011, 4'b0000, 4'b1010, 3'b000, 4'b0000, 2'd1, 1, 0);
        v(4'b1011, 4'b0000, 4'b0010, 3'b100, 4'b0000, 2'd1, 1, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd1, 0, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b1000, 2'd3, 0, 0);
        v(4'b1011, 4'b0000, 4'b1000, 3'b000, 4'b0000, 2'd3, 1, 0);
        v(4'b1011, 4'b0000, 4'b1000, 3'b001, 4'b0000, 2'd3, 1, 0);
        v(4'b1011, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd3, 0, 0);
        // request withdrawn during grant advances pointer
        v(4'b0001, 4'b0000, 4'b0000, 3'b000, 4'b0001, 2'd0, 0, 0);
        v(4'b0000, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd0, 0, 0);
        v(4'b0011, 4'b0000, 4'b0000, 3'b000, 4'b0010, 2'd1, 0, 0);
        v(4'b0000, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd1, 0, 0);
        // bus lock held by master 1
        v(4'b0010, 4'b0010, 4'b0000, 3'b000, 4'b0010, 2'd1, 0, 1);
        v(4'b0011, 4'b0010, 4'b0010, 3'b000, 4'b0000, 2'd1, 1, 1);
        v(4'b0011, 4'b0010, 4'b0000, 3'b000, 4'b0010, 2'd1, 0, 1);
        v(4'b0011, 4'b0010, 4'b0010, 3'b000, 4'b0000, 2'd1, 1, 1);
        v(4'b0011, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd1, 0, 0);
        v(4'b0011, 4'b0000, 4'b0000, 3'b000, 4'b0001, 2'd0, 0, 0);
        v(4'b0000, 4'b0000, 4'b0000, 3'b000, 4'b0000, 2'd0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_timeout", {31'd0, tout}, 32'd0);
        chk("rst_owner", {30'd0, own}, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req   = tbl[i].req;
            lock  = tbl[i].lock;
            sel   = tbl[i].sel;
            ack   = tbl[i].acks[0];
            retry = tbl[i].acks[1];
            err   = tbl[i].acks[2];
            step();
            chk($sformatf("vec%0d_grant", i), {28'd0, grant},
                {28'd0, tbl[i].g});
            chk($sformatf("vec%0d_owner", i), {30'd0, own},
                {30'd0, tbl[i].own});
            chk($sformatf("vec%0d_timeout", i), {31'd0, tout},
                {31'd0, tbl[i].to});
            chk($sformatf("vec%0d_select", i), {31'd0, osel},
                {31'd0, tbl[i].osel});
            chk($sformatf("vec%0d_buslock", i), {31'd0, olock},
                {31'd0, tbl[i].olock});
        end
        ack   = 1'b0;
        retry = 1'b0;
        err   = 1'b0;
        lock  = '0;

        // timeout: master 0 selected with no ack
        req = 4'b0001;
        sel = 4'b0000;
        step();
        chk("to_grant0", {28'd0, grant}, 32'h1);
        req = 4'b0011;
        sel = 4'b0001;
        step();
        first  = 0;
        pulses = 0;
        gseen  = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (tout) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (grant != 4'b0000) gseen++;
        end
        chk("to_first_cycle", first, 16);
        chk("to_pulse_count", pulses, 1);
        chk("to_no_grant_while_sel", gseen, 0);
        sel = 4'b0000;
        step();
        chk("to_release_grant", {28'd0, grant}, 32'h0);
        step();
        chk("to_next_grant", {28'd0, grant}, 32'h2);
        chk("to_next_owner", {30'd0, own}, 32'd1);

        // grant never used: abort after limit, no timeout pulse
        drop_c = 0;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (tout) pulses++;
            if (grant != 4'b0010) begin
                drop_c = c;
                break;
            end
        end
        chk("gto_drop_cycle", drop_c, 16);
        chk("gto_no_pulse", pulses, 0);
        chk("gto_drop_grant", {28'd0, grant}, 32'h0);
        step();
        chk("gto_ptr_adv_grant", {28'd0, grant}, 32'h1);

        // retry at cycle 10 restarts the window
        req = 4'b0001;
        sel = 4'b0001;
        step();
        first  = 0;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            retry = (c == 10);
            step();
            if (tout) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        retry = 1'b0;
        chk("retry_first_cycle", first, 26);
        chk("retry_pulse_count", pulses, 1);
        sel = 4'b0000;
        req = 4'b0000;
        step();

        // ack on the limit cycle wins, then reset while timeout is high
        req = 4'b0001;
        step();
        chk("ack_grant0", {28'd0, grant}, 32'h1);
        sel = 4'b0001;
        step();
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            ack = (c == 16);
            step();
            if (tout) begin
                first = c;
                break;
            end
        end
        ack = 1'b0;
        chk("acklim_first_cycle", first, 32);
        chk("acklim_pulse_high", {31'd0, tout}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_timeout", {31'd0, tout}, 32'd0);
        chk("rst_async_grant_a", {28'd0, grant}, 32'h0);
        sel = 4'b0000;
        req = 4'b1000;
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_pre_grant3", {28'd0, grant}, 32'h8);
        chk("rst_pre_owner3", {30'd0, own}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_grant", {28'd0, grant}, 32'h0);
        chk("rst_async_owner", {30'd0, own}, 32'd0);
        req = 4'b1001;
        step();
        chk("rst_held_grant", {28'd0, grant}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("rst_after_grant", {28'd0, grant}, 32'h1);
        chk("rst_after_owner", {30'd0, own}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
